// File: rtl/reception_token_dispatcher.sv
// Reception token dispatcher: issues sequential patient tokens, queues them per doctor, serves one at a time.
// Latency: token_valid 1 cycle after msg_valid; earliest serving 2 cycles after msg_valid (no FIFO bypass).
// Backpressure: a full destination FIFO refuses the msg (counted in reject_cnt); done_X frees doctor X.
//
// Ports: clk, rst (sync, active-high); msg/msg_valid from the desk; done_A/done_B from the doctors;
//        token_out/token_dest/token_valid issue pulse; now_X/serving_X/qcount_X/full_X per doctor display;
//        reject_cnt saturating refusal count.
// Optional feature: define SPILL_ROUTE_EN to route msg 00 to the less loaded doctor (tie -> A).

// Per-doctor token queue. The caller never pushes when full or pops when empty.
module rtd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 push_dat,
   input  logic                         pop,
   output logic [W-1:0]                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Storage needs no reset; count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign head = mem[rd_ptr];
endmodule

module reception_token_dispatcher #(
   parameter int DEPTH   = 4,
   parameter int TOKEN_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   msg,
   input  logic                         msg_valid,
   input  logic                         done_A,
   input  logic                         done_B,
   output logic [TOKEN_W-1:0]           token_out,
   output logic                         token_dest,
   output logic                         token_valid,
   output logic [TOKEN_W-1:0]           now_A,
   output logic [TOKEN_W-1:0]           now_B,
   output logic                         serving_A,
   output logic                         serving_B,
   output logic [$clog2(DEPTH+1)-1:0]   qcount_A,
   output logic [$clog2(DEPTH+1)-1:0]   qcount_B,
   output logic                         full_A,
   output logic                         full_B,
   output logic [7:0]                   reject_cnt
);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic {IDLE = 1'b0, SERVING = 1'b1} serve_state_t;

   serve_state_t       state_a, state_a_nxt;
   serve_state_t       state_b, state_b_nxt;
   logic               pop_a, pop_b;
   logic               push_a, push_b;
   logic [TOKEN_W-1:0] head_a, head_b;
   logic [TOKEN_W-1:0] token_ctr;
   logic               req_vld;
   logic               req_dest;
   logic               dest_full;
   logic               accept;
   logic               reject;

   rtd_fifo #(.DEPTH(DEPTH), .W(TOKEN_W)) u_fifo_a (
      .clk(clk), .rst(rst), .push(push_a), .push_dat(token_ctr),
      .pop(pop_a), .head(head_a), .count(qcount_A)
   );

   rtd_fifo #(.DEPTH(DEPTH), .W(TOKEN_W)) u_fifo_b (
      .clk(clk), .rst(rst), .push(push_b), .push_dat(token_ctr),
      .pop(pop_b), .head(head_b), .count(qcount_B)
   );

   // full comes from the registered count, so a push into a full FIFO is refused
   // even if that FIFO pops in the same cycle.
   assign full_A = (qcount_A == CW'(DEPTH));
   assign full_B = (qcount_B == CW'(DEPTH));

   // Route decode and admission.
   always_comb begin
      req_vld  = 1'b0;
      req_dest = 1'b0;
      case (msg)
         2'b10: begin req_vld = 1'b1; req_dest = 1'b0; end
         2'b01: begin req_vld = 1'b1; req_dest = 1'b1; end
`ifdef SPILL_ROUTE_EN
         // Spill to the shorter waiting line; equal lines go to A.
         2'b00: begin req_vld = 1'b1; req_dest = (qcount_B < qcount_A); end
`endif
         default: ;
      endcase
      dest_full = req_dest ? full_B : full_A;
      accept    = msg_valid & req_vld & ~dest_full;
      reject    = msg_valid & ~accept;
   end

   assign push_a = accept & ~req_dest;
   assign push_b = accept &  req_dest;

   // Issue pulse and token counter (wraps silently).
   always_ff @(posedge clk) begin
      if (rst) begin
         token_ctr   <= '0;
         token_out   <= '0;
         token_dest  <= 1'b0;
         token_valid <= 1'b0;
      end else begin
         token_valid <= accept;
         if (accept) begin
            token_out  <= token_ctr;
            token_dest <= req_dest;
            token_ctr  <= token_ctr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reject_cnt <= '0;
      end else if (reject && reject_cnt != 8'hFF) begin
         reject_cnt <= reject_cnt + 1'b1;
      end
   end

   // Serve FSMs: a doctor always passes through IDLE after done, so the next
   // pop lands at least one cycle after the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_a <= IDLE;
         state_b <= IDLE;
      end else begin
         state_a <= state_a_nxt;
         state_b <= state_b_nxt;
      end
   end

   always_comb begin
      state_a_nxt = state_a;
      state_b_nxt = state_b;
      pop_a       = 1'b0;
      pop_b       = 1'b0;
      case (state_a)
         IDLE:    if (qcount_A != '0) begin state_a_nxt = SERVING; pop_a = 1'b1; end
         SERVING: if (done_A) state_a_nxt = IDLE;
         default: state_a_nxt = IDLE;
      endcase
      case (state_b)
         IDLE:    if (qcount_B != '0) begin state_b_nxt = SERVING; pop_b = 1'b1; end
         SERVING: if (done_B) state_b_nxt = IDLE;
         default: state_b_nxt = IDLE;
      endcase
   end

   // now_X keeps its last value after the patient leaves.
   always_ff @(posedge clk) begin
      if (rst) begin
         now_A <= '0;
         now_B <= '0;
      end else begin
         if (pop_a) now_A <= head_a;
         if (pop_b) now_B <= head_b;
      end
   end

   assign serving_A = (state_a == SERVING);
   assign serving_B = (state_b == SERVING);
endmodule

// File: tb/tb_reception_token_dispatcher.sv
module tb_reception_token_dispatcher;
   localparam int DEPTH   = 4;
   localparam int TOKEN_W = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          msg;
   logic                msg_valid;
   logic                done_A, done_B;
   logic [TOKEN_W-1:0]  token_out, now_A, now_B;
   logic                token_dest, token_valid, serving_A, serving_B, full_A, full_B;
   logic [2:0]          qcount_A, qcount_B;
   logic [7:0]          reject_cnt;

   always #5 clk = ~clk;

   reception_token_dispatcher #(.DEPTH(DEPTH), .TOKEN_W(TOKEN_W)) dut (
      .clk(clk), .rst(rst), .msg(msg), .msg_valid(msg_valid),
      .done_A(done_A), .done_B(done_B),
      .token_out(token_out), .token_dest(token_dest), .token_valid(token_valid),
      .now_A(now_A), .now_B(now_B), .serving_A(serving_A), .serving_B(serving_B),
      .qcount_A(qcount_A), .qcount_B(qcount_B), .full_A(full_A), .full_B(full_B),
      .reject_cnt(reject_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: waiting lines as queues, doctors as "busy + current token".
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   bit         m_srv_a, m_srv_b;
   logic [7:0] m_now_a, m_now_b;
   logic [7:0] m_ctr, m_rej, m_tok;
   bit         m_tv, m_dst;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic model_step();
      int dest;
      bit acc;
      m_tv = 1'b0;
      if (rst) begin
         qa.delete(); qb.delete();
         m_srv_a = 0; m_srv_b = 0; m_now_a = 0; m_now_b = 0;
         m_ctr = 0; m_rej = 0; m_tok = 0; m_dst = 0;
         return;
      end
      dest = -1;
      acc  = 0;
      if (msg_valid) begin
         if (msg == 2'b10) dest = 0;
         else if (msg == 2'b01) dest = 1;
`ifdef SPILL_ROUTE_EN
         else if (msg == 2'b00) dest = (qb.size() < qa.size()) ? 1 : 0;
`endif
         if (dest == 0 && qa.size() < DEPTH) acc = 1;
         if (dest == 1 && qb.size() < DEPTH) acc = 1;
         if (!acc && m_rej != 8'd255) m_rej++;
      end
      // Doctors act on the lines as they stood before this cycle's arrival.
      if (m_srv_a) begin
         if (done_A) m_srv_a = 0;
      end else if (qa.size() > 0) begin
         m_now_a = qa.pop_front(); m_srv_a = 1;
      end
      if (m_srv_b) begin
         if (done_B) m_srv_b = 0;
      end else if (qb.size() > 0) begin
         m_now_b = qb.pop_front(); m_srv_b = 1;
      end
      if (acc) begin
         if (dest == 0) qa.push_back(m_ctr); else qb.push_back(m_ctr);
         m_tv = 1; m_tok = m_ctr; m_dst = (dest == 1); m_ctr++;
      end
   endtask

   task automatic compare_all();
      chk("tvld", token_valid, m_tv);
      if (m_tv || rst) begin
         chk("tok", token_out, m_tok);
         chk("dst", token_dest, m_dst);
      end
      chk("srvA", serving_A, m_srv_a);
      chk("srvB", serving_B, m_srv_b);
      chk("nowA", now_A, m_now_a);
      chk("nowB", now_B, m_now_b);
      chk("qcA", qcount_A, qa.size());
      chk("qcB", qcount_B, qb.size());
      chk("fullA", full_A, qa.size() == DEPTH);
      chk("fullB", full_B, qb.size() == DEPTH);
      chk("rej", reject_cnt, m_rej);
   endtask

   // One clock: model consumes the current inputs, DUT samples them, check #1 later.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic strobe(input logic [1:0] m);
      msg = m; msg_valid = 1'b1;
      cycle();
      msg_valid = 1'b0;
   endtask

   task automatic pulse_done_a();
      done_A = 1'b1;
      cycle();
      done_A = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; msg = 2'b00; msg_valid = 1'b0; done_A = 1'b0; done_B = 1'b0;
      @(negedge clk);
      do_reset();
      chk("rst_rej", reject_cnt, 0);
      chk("rst_srvA", serving_A, 0);

      // 1: first token to A, served two cycles after the strobe.
      strobe(2'b10);
      chk("t1_tok", token_out, 0);
      chk("t1_dst", token_dest, 0);
      cycle();
      chk("t1_srvA", serving_A, 1);
      chk("t1_nowA", now_A, 0);

      // 2: fill B, sixth strobe refused.
      do_reset();
      for (int i = 0; i < 5; i++) strobe(2'b01);
      chk("t2_qcB", qcount_B, 4);
      chk("t2_fullB", full_B, 1);
      strobe(2'b01);
      chk("t2_tvld", token_valid, 0);
      chk("t2_rej", reject_cnt, 1);

      // 3: A serving token 3 with 4,5 waiting; done -> one idle cycle -> token 4.
      do_reset();
      for (int i = 0; i < 4; i++) strobe(2'b10);
      cycle();
      pulse_done_a(); cycle();
      pulse_done_a(); cycle();
      strobe(2'b10); strobe(2'b10);
      pulse_done_a(); cycle();
      chk("t3_pre_now", now_A, 3);
      chk("t3_pre_qc", qcount_A, 2);
      pulse_done_a();
      chk("t3_gap", serving_A, 0);
      cycle();
      chk("t3_nowA", now_A, 4);
      chk("t3_srvA", serving_A, 1);
      chk("t3_qcA", qcount_A, 1);

      // 4: counter wrap 255 -> 0.
      do_reset();
      done_A = 1'b1; done_B = 1'b1;
      n = 0;
      while (m_ctr != 8'd255 && n < 2000) begin
         msg = n[0] ? 2'b01 : 2'b10; msg_valid = 1'b1;
         cycle();
         n++;
      end
      msg_valid = 1'b0;
      chk("t4_bound", n < 2000, 1);
      cycle(); cycle();
      strobe(2'b10);
      chk("t4_tok255", token_out, 255);
      strobe(2'b01);
      chk("t4_tvld", token_valid, 1);
      chk("t4_tok0", token_out, 0);
      done_A = 1'b0; done_B = 1'b0;

      // 5: msg 00 with A holding two waiting tokens, B empty.
      do_reset();
      for (int i = 0; i < 3; i++) strobe(2'b10);
      cycle(); cycle();
      chk("t5_qcA", qcount_A, 2);
      strobe(2'b00);
`ifdef SPILL_ROUTE_EN
      chk("t5_tvld", token_valid, 1);
      chk("t5_dst", token_dest, 1);
`else
      chk("t5_tvld", token_valid, 0);
      chk("t5_rej", reject_cnt, 1);
`endif

      // 6: reset while both doctors busy with waiting tokens.
      do_reset();
      for (int i = 0; i < 4; i++) strobe(i[0] ? 2'b01 : 2'b10);
      cycle(); cycle(); cycle();
      chk("t6_busyB", serving_B, 1);
      do_reset();
      chk("t6_nowB", now_B, 0);
      chk("t6_srvB", serving_B, 0);
      chk("t6_qcA", qcount_A, 0);
      chk("t6_tvld", token_valid, 0);
      strobe(2'b10);
      chk("t6_tok", token_out, 0);

      // reject_cnt saturation.
      do_reset();
      msg = 2'b11; msg_valid = 1'b1;
      for (int i = 0; i < 260; i++) cycle();
      msg_valid = 1'b0;
      chk("sat_rej", reject_cnt, 255);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         msg       = 2'($urandom_range(0, 3));
         msg_valid = ($urandom_range(0, 3) != 0);
         done_A    = ($urandom_range(0, 3) == 0);
         done_B    = ($urandom_range(0, 3) == 0);
         rst       = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst = 1'b0; msg_valid = 1'b0; done_A = 1'b0; done_B = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
